settings_input: RTL and testbench

SETTINGS_INPUT -- requirements
Module: settings_input

---
 rtl/settings_input_if.sv | 28 ++
 rtl/settings_input.sv | 139 +++++++++++++
 tb/tb_settings_input.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/settings_input_if.sv
// Settings/game-status bundle between the button panel, the game logic
// and the settings block.
interface settings_input_if;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic       BTN_SEL;
    logic       BTN_START;
    logic       MOVE;
    logic       WIN;
    logic [3:0] COLOR_NUM;
    logic [4:0] SIZE;
    logic       sORc;
    logic       MODE;
    logic [7:0] TRIES;
    logic [7:0] TOTAL_TRIES;
    logic       WON;
    logic       LOST;

    modport master (
        output BTN_UP, BTN_DOWN, BTN_SEL, BTN_START, MOVE, WIN,
        input  COLOR_NUM, SIZE, sORc, MODE, TRIES, TOTAL_TRIES, WON, LOST
    );

    modport slave (
        input  BTN_UP, BTN_DOWN, BTN_SEL, BTN_START, MOVE, WIN,
        output COLOR_NUM, SIZE, sORc, MODE, TRIES, TOTAL_TRIES, WON, LOST
    );
endinterface

// File: rtl/settings_input.sv
// Debounced button front end plus the setup/play/done game-settings FSM:
// board size and colour count are edited in setup, moves are counted in play.
module settings_input #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SIZE_MIN        = 2,
    parameter int SIZE_MAX        = 14,
    parameter int COLOR_MIN       = 3,
    parameter int COLOR_MAX       = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    settings_input_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] SZ_MIN = 5'(SIZE_MIN);
    localparam logic [4:0] SZ_MAX = 5'(SIZE_MAX);
    localparam logic [3:0] CL_MIN = 4'(COLOR_MIN);
    localparam logic [3:0] CL_MAX = 4'(COLOR_MAX);

    typedef enum logic [1:0] {SETUP, PLAY, DONE} state_t;

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    lvl;
    logic [3:0]    lvl_q;
    logic [3:0]    press;
    logic [CW-1:0] cnt [4];

    // bit order: 0 = up, 1 = down, 2 = select, 3 = start
    assign raw = {bus.BTN_START, bus.BTN_SEL, bus.BTN_DOWN, bus.BTN_UP};
    assign press = lvl & ~lvl_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_q <= lvl;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        lvl[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    state_t     state;
    logic       mode;
    logic       sorc;
    logic [4:0] size;
    logic [3:0] color;
    logic [7:0] tries;
    logic [7:0] total;
    logic       won;
    logic       lost;
    logic [7:0] tries_inc;
    logic [7:0] total_new;

    assign tries_inc = (tries >= 8'd99) ? tries : tries + 8'd1;
    assign total_new = {3'b000, size} + {3'b000, color, 1'b0};

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= SETUP;
            mode  <= 1'b0;
            sorc  <= 1'b1;
            size  <= 5'd10;
            color <= 4'd6;
            tries <= 8'd0;
            total <= 8'd0;
            won   <= 1'b0;
            lost  <= 1'b0;
        end else begin
            unique case (state)
                SETUP: begin
                    if (press[2]) sorc <= ~sorc;
                    if (press[0] ^ press[1]) begin
                        if (sorc) begin
                            if (press[0] && size < SZ_MAX) size <= size + 5'd1;
                            if (press[1] && size > SZ_MIN) size <= size - 5'd1;
                        end else begin
                            if (press[0] && color < CL_MAX) color <= color + 4'd1;
                            if (press[1] && color > CL_MIN) color <= color - 4'd1;
                        end
                    end
                    if (press[3]) begin
                        state <= PLAY;
                        mode  <= 1'b1;
                        total <= total_new;
                        tries <= 8'd0;
                        won   <= 1'b0;
                        lost  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (bus.MOVE) tries <= tries_inc;
                    // a win on the final allowed move still counts as a win
                    if (bus.WIN) begin
                        state <= DONE;
                        won   <= 1'b1;
                    end else if (bus.MOVE && tries_inc == total) begin
                        state <= DONE;
                        lost  <= 1'b1;
                    end
                end
                DONE: begin
                    if (press[3]) begin
                        state <= SETUP;
                        mode  <= 1'b0;
                    end
                end
                default: state <= SETUP;
            endcase
        end
    end

    assign bus.MODE        = mode;
    assign bus.sORc        = sorc;
    assign bus.SIZE        = size;
    assign bus.COLOR_NUM   = color;
    assign bus.TRIES       = tries;
    assign bus.TOTAL_TRIES = total;
    assign bus.WON         = won;
    assign bus.LOST        = lost;
endmodule

// File: tb/tb_settings_input.sv
// Scoreboard bench for settings_input: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_settings_input;
    localparam int D = 4;

    logic CLOCK;
    logic RESET;

    settings_input_if bus ();

    settings_input #(
        .DEBOUNCE_CYCLES(D),
        .SIZE_MIN(2),
        .SIZE_MAX(14),
        .COLOR_MIN(3),
        .COLOR_MAX(8)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus(bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        string name;
        int mode;
        int sorc;
        int size;
        int color;
        int tries;
        int total;
        int won;
        int lost;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.name, ".mode"},  int'(bus.MODE),        e.mode);
            chk({e.name, ".sorc"},  int'(bus.sORc),        e.sorc);
            chk({e.name, ".size"},  int'(bus.SIZE),        e.size);
            chk({e.name, ".color"}, int'(bus.COLOR_NUM),   e.color);
            chk({e.name, ".tries"}, int'(bus.TRIES),       e.tries);
            chk({e.name, ".total"}, int'(bus.TOTAL_TRIES), e.total);
            chk({e.name, ".won"},   int'(bus.WON),         e.won);
            chk({e.name, ".lost"},  int'(bus.LOST),        e.lost);
        end
    end

    task automatic push(input string nm, input int mode, input int sorc,
                        input int size, input int color, input int tries,
                        input int total, input int won, input int lost);
        exp_t x;
        x.name = nm;
        x.mode = mode;
        x.sorc = sorc;
        x.size = size;
        x.color = color;
        x.tries = tries;
        x.total = total;
        x.won = won;
        x.lost = lost;
        sb.push_back(x);
    endtask

    task automatic settle();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] m);
        bus.BTN_UP    = m[0];
        bus.BTN_DOWN  = m[1];
        bus.BTN_SEL   = m[2];
        bus.BTN_START = m[3];
    endtask

    // m: bit0 up, bit1 down, bit2 select, bit3 start
    task automatic press(input logic [3:0] m);
        @(negedge CLOCK);
        set_btn(m);
        repeat (D + 3) @(posedge CLOCK);
        @(negedge CLOCK);
        set_btn(4'b0000);
        repeat (D + 3) @(posedge CLOCK);
    endtask

    task automatic pulse(input logic mv, input logic wn);
        @(negedge CLOCK);
        bus.MOVE = mv;
        bus.WIN  = wn;
        @(negedge CLOCK);
        bus.MOVE = 1'b0;
        bus.WIN  = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        set_btn(4'b0000);
        bus.MOVE = 1'b0;
        bus.WIN  = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1 push("reset", 0, 1, 10, 6, 0, 0, 0, 0);
        @(negedge CLOCK);
        RESET = 1'b0;

        @(negedge CLOCK);
        bus.BTN_UP = 1'b1;
        repeat (3) @(negedge CLOCK);
        bus.BTN_UP = 1'b0;
        repeat (8) @(posedge CLOCK);
        #1 push("glitch", 0, 1, 10, 6, 0, 0, 0, 0);

        @(negedge CLOCK);
        bus.BTN_UP = 1'b1;
        repeat (D + 2) @(posedge CLOCK);
        #1 push("up_edge6", 0, 1, 10, 6, 0, 0, 0, 0);
        settle();
        push("up_edge7", 0, 1, 11, 6, 0, 0, 0, 0);
        repeat (10) @(posedge CLOCK);
        #1 push("up_hold", 0, 1, 11, 6, 0, 0, 0, 0);
        @(negedge CLOCK);
        bus.BTN_UP = 1'b0;
        repeat (8) @(posedge CLOCK);

        repeat (6) press(4'b0001);
        settle();
        push("size_sat", 0, 1, 14, 6, 0, 0, 0, 0);
        press(4'b0100);
        repeat (5) press(4'b0010);
        settle();
        push("color_sat", 0, 0, 14, 3, 0, 0, 0, 0);

        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        settle();
        push("reset2", 0, 1, 10, 6, 0, 0, 0, 0);

        press(4'b0011);
        settle();
        push("updown", 0, 1, 10, 6, 0, 0, 0, 0);
        pulse(1'b1, 1'b1);
        settle();
        push("move_setup", 0, 1, 10, 6, 0, 0, 0, 0);

        press(4'b1000);
        settle();
        push("start", 1, 1, 10, 6, 0, 22, 0, 0);
        press(4'b0001);
        press(4'b0100);
        press(4'b1000);
        settle();
        push("play_ign", 1, 1, 10, 6, 0, 22, 0, 0);

        repeat (21) pulse(1'b1, 1'b0);
        settle();
        push("tries21", 1, 1, 10, 6, 21, 22, 0, 0);
        pulse(1'b1, 1'b0);
        settle();
        push("loss", 1, 1, 10, 6, 22, 22, 0, 1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        settle();
        push("done_ign", 1, 1, 10, 6, 22, 22, 0, 1);

        press(4'b1000);
        settle();
        push("to_setup", 0, 1, 10, 6, 22, 22, 0, 1);
        press(4'b1000);
        settle();
        push("restart", 1, 1, 10, 6, 0, 22, 0, 0);

        repeat (21) pulse(1'b1, 1'b0);
        settle();
        push("pre_sim", 1, 1, 10, 6, 21, 22, 0, 0);
        pulse(1'b1, 1'b1);
        settle();
        push("sim", 1, 1, 10, 6, 22, 22, 1, 0);
        press(4'b1000);
        settle();
        push("win_setup", 0, 1, 10, 6, 22, 22, 1, 0);

        press(4'b1000);
        repeat (3) pulse(1'b1, 1'b0);
        settle();
        push("pre_rst", 1, 1, 10, 6, 3, 22, 0, 0);

        @(posedge CLOCK);
        #2 RESET = 1'b1;
        #1 push("async_rst", 0, 1, 10, 6, 0, 0, 0, 0);
        @(posedge CLOCK);
        #2 RESET = 1'b0;

        repeat (3) @(negedge CLOCK);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
